// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative MUL/DIV/MOD.
// Registered result and flags behind valid/ready handshakes.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;
    localparam logic [3:0] OP_MOD = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [SW-1:0]        cnt_q;
    logic                 multi, last;

    logic [SW-1:0]        s;
    logic [WIDTH:0]       sum, dif, shl, shr, sar;
    logic [WIDTH-1:0]     r;
    logic                 c, v, z, n;

    logic [WIDTH:0]       mul_sum, shifted;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    logic [WIDTH-1:0]     rem_next, m_r;
    logic                 ge, m_c;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign multi = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    assign last  = (cnt_q == LAST);

    always_comb begin
        s   = b[SW-1:0];
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        shl = {1'b0, a} << s;
        shr = {a, 1'b0} >> s;
        sar = $signed({a, 1'b0}) >>> s;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        unique case (op)
            OP_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                r = dif[WIDTH-1:0];
                c = dif[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_NEG: begin
                r = '0 - a;
                v = (a == MINV);
            end
            OP_SHL: begin
                r = shl[WIDTH-1:0];
                c = shl[WIDTH];
            end
            OP_SHR: begin
                r = shr[WIDTH:1];
                c = shr[0];
            end
            OP_SAR: begin
                r = sar[WIDTH:1];
                c = sar[0];
            end
            OP_INC: begin
                r = a + ONE;
                c = (a == ONES);
                v = (a == MAXP);
            end
            OP_DEC: begin
                r = a - ONE;
                c = (a == '0);
                v = (a == MINV);
            end
            default: r = '0;
        endcase
        z = (r == '0);
        n = r[WIDTH-1];
        // CMP reports a, but its zero/negative reflect a-b
        if (op == OP_CMP) r = a;
    end

    always_comb begin
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, p_q[WIDTH-1:1]};
        shifted  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, b_q});
        rem_next = WIDTH'(ge ? shifted - {1'b0, b_q} : shifted);
        div_next = {rem_next, p_q[WIDTH-2:0], ge};
        p_d      = (op_q == OP_MUL) ? mul_next : div_next;
        unique case (op_q)
            OP_MUL:  m_r = mul_next[WIDTH-1:0];
            OP_DIV:  m_r = div_next[WIDTH-1:0];
            default: m_r = div_next[2*WIDTH-1:WIDTH];
        endcase
        m_c = (op_q == OP_MUL) ? |mul_next[2*WIDTH-1:WIDTH] : (b_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = multi ? BUSY : DONE;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else if (in_ready && in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt_q <= '0;
            p_q   <= {{WIDTH{1'b0}}, (op == OP_MUL) ? b : a};
            if (!multi) begin
                result   <= r;
                zero     <= z;
                carry    <= c;
                overflow <= v;
                negative <= n;
            end
        end else if (state_q == BUSY) begin
            p_q   <= p_d;
            cnt_q <= cnt_q + SW'(1);
            if (last) begin
                result   <= m_r;
                zero     <= (m_r == '0);
                carry    <= m_c;
                overflow <= 1'b0;
                negative <= m_r[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic
// scored against an arithmetic reference model on every cycle.
module tb_alu_seq;
    localparam int W = 8;
    localparam int MASK = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, carry, overflow, negative;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int res;
        bit z, c, v, n;
        int due;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic int pk(logic [7:0] r, logic fz, logic fc,
                              logic fv, logic fn);
        return int'({r, fz, fc, fv, fn});
    endfunction

    function automatic exp_t model(int o, int x, int y);
        exp_t e;
        int sx, sy, t, s;
        e = '{default: 0};
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        s = y % W;
        case (o)
            0: begin
                t = x + y;
                e.res = t & MASK;
                e.c = (t > MASK);
                e.v = (sx + sy > 127) || (sx + sy < -128);
            end
            1, 13: begin
                e.res = (x - y) & MASK;
                e.c = (x < y);
                e.v = (sx - sy > 127) || (sx - sy < -128);
            end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = (~x) & MASK;
            6: begin
                e.res = (-x) & MASK;
                e.v = (-sx > 127);
            end
            7: begin
                e.res = (x << s) & MASK;
                e.c = (s != 0) && (((x >> (W - s)) & 1) != 0);
            end
            8: begin
                e.res = x >> s;
                e.c = (s != 0) && (((x >> (s - 1)) & 1) != 0);
            end
            9: begin
                e.res = (sx >>> s) & MASK;
                e.c = (s != 0) && (((x >> (s - 1)) & 1) != 0);
            end
            10: begin
                e.res = (x + 1) & MASK;
                e.c = (x == MASK);
                e.v = (sx + 1 > 127);
            end
            11: begin
                e.res = (x - 1) & MASK;
                e.c = (x == 0);
                e.v = (sx - 1 < -128);
            end
            12: begin
                t = x * y;
                e.res = t & MASK;
                e.c = (t > MASK);
            end
            14: begin
                e.res = (y == 0) ? MASK : x / y;
                e.c = (y == 0);
            end
            default: begin
                e.res = (y == 0) ? x : x % y;
                e.c = (y == 0);
            end
        endcase
        e.z = (e.res == 0);
        e.n = (e.res >= 128);
        if (o == 13) e.res = x;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            check("rst_flags", pk(result, zero, carry, overflow, negative), 0);
            check("rst_valid", int'(out_valid), 0);
        end else begin
            check("in_ready", int'(in_ready), int'(q.size() == 0));
            if (q.size() > 0 && cyc < q[0].due)
                check("early_valid", int'(out_valid), 0);
            if (q.size() > 0 && cyc == q[0].due)
                check("latency", int'(out_valid), 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    check("result",
                          pk(result, zero, carry, overflow, negative),
                          pk(8'(q[0].res), q[0].z, q[0].c, q[0].v, q[0].n));
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e = model(int'(op), int'(a), int'(b));
                e.due = cyc + ((op == 12 || op == 14 || op == 15) ? W + 1 : 1);
                q.push_back(e);
            end
        end
    end

    task automatic send(input int o, input int x, input int y);
        int i;
        i = 0;
        while (!in_ready && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        in_valid = 1'b1;
        op = 4'(o);
        a = 8'(x);
        b = 8'(y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 4'($urandom);
    endtask

    task automatic wait_out(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 50);
        if (!out_valid) check("wait_timeout", 0, 1);
    endtask

    task automatic expect_op(input string nm, input int o, input int x,
                             input int y, input int res, input int lat,
                             input bit fz, input bit fc, input bit fv,
                             input bit fn);
        int k;
        send(o, x, y);
        wait_out(k);
        check({nm, "_lat"}, k, lat);
        check(nm, pk(result, zero, carry, overflow, negative),
              pk(8'(res), fz, fc, fv, fn));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7f;
            3: return 8'h80;
            4: return 8'hff;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pk(result, zero, carry, overflow, negative), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("ready_after_rst", int'(in_ready), 1);

        expect_op("add_ovf", 0, 'h7f, 'h01, 'h80, 1, 0, 0, 1, 1);
        expect_op("mul_wrap", 12, 'h10, 'h10, 'h00, 9, 1, 1, 0, 0);
        expect_op("div", 14, 200, 7, 'h1c, 9, 0, 0, 0, 0);
        expect_op("mod", 15, 200, 7, 'h04, 9, 0, 0, 0, 0);
        expect_op("div0", 14, 'h55, 0, 'hff, 9, 0, 1, 0, 1);
        expect_op("mod0", 15, 'h55, 0, 'h55, 9, 0, 1, 0, 0);
        expect_op("shl", 7, 'h81, 1, 'h02, 1, 0, 1, 0, 0);
        expect_op("shr0", 8, 'h81, 0, 'h81, 1, 0, 0, 0, 1);
        expect_op("sar7", 9, 'h80, 7, 'hff, 1, 0, 0, 0, 1);
        expect_op("cmp_eq", 13, 'h05, 'h05, 'h05, 1, 1, 0, 0, 0);
        expect_op("neg_min", 6, 'h80, 0, 'h80, 1, 0, 0, 1, 1);
        expect_op("inc_max", 10, 'hff, 0, 'h00, 1, 1, 1, 0, 0);

        out_ready = 1'b0;
        send(1, 'h00, 'h01);
        wait_out(k);
        for (int i = 0; i < 5; i++) begin
            check("sub_hold", pk(result, zero, carry, overflow, negative),
                  pk(8'hff, 0, 1, 0, 1));
            check("sub_hold_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_hs", int'(in_ready), 1);

        send(12, 'h10, 'h10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_flags", pk(result, zero, carry, overflow, negative), 0);
        check("abort_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", int'(in_ready), 1);
        expect_op("add_after_rst", 0, 3, 4, 'h07, 1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom);
            a = pick();
            b = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
